pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush arbiter for the in-order pipeline, generalised to NSTAGE stages. It collects per-stage stop requests and produces a thermometer stall vector in which the deepest requester wins. It opens a flush window of programmable length on an exception/redirect, and keeps saturating performance counters of stall and flush cycles. It sits beside the pipeline registers and drives their stall/flush inputs.

Parameters:
NSTAGE, 6, number of pipeline-register stages; width of stop_req and stall.
FLUSH_HOLD, 2, cycles flush_o stays asserted per flush event (legal range 1..15).
CNT_W, 32, width of each performance counter.
WD_LIMIT, 1024, watchdog threshold in consecutive stall cycles (used only with the optional feature).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
stop_req  in  NSTAGE  bit k=1: stage k requests a stall; bit 0 is the front of the pipe.
flush_i  in  1  flush request pulse (exception/redirect).
cnt_clr  in  1  synchronous clear of both counters.
stall  out  NSTAGE  thermometer stall vector; bit j=1 holds stage j.
flush_o  out  1  flush all pipeline registers.
flush_busy  out  1  flush window active beyond the current cycle (registered).
stall_src  out  $clog2(NSTAGE)  index of the winning requester; 0 when idle.
stall_cycles  out  CNT_W  count of cycles with stall!=0.
flush_cycles  out  CNT_W  count of cycles with flush_o=1.

Behaviour:
- Reset (rst=0, async): flush counter=0, both perf counters=0. While reset is asserted, the combinational outputs read stall=0, flush_o=0, stall_src=0, flush_busy=0.
- Flush window:
  - fcnt is a 4-bit down-counter.
  - When flush_i=1, fcnt loads FLUSH_HOLD-1 at the next edge.
  - Otherwise, when fcnt!=0, fcnt decrements.
  - flush_o = flush_i | (fcnt!=0), a combinational path from flush_i with zero latency.
  - flush_busy = (fcnt!=0).
  - The flush_o pulse lasts FLUSH_HOLD cycles.
  - flush_i arriving during an open window reloads fcnt and extends the window; the window does not stack.
  - FLUSH_HOLD=1: flush_o equals flush_i and fcnt stays 0.
- Stall:
  - Combinational and zero latency.
  - When flush_o=1, stall=0 and stall_src=0, because flush overrides all stop requests.
  - Otherwise, let h be the highest set bit of stop_req. Then stall[j]=1 for j<=h, and stall_src=h.
  - stop_req=0 gives stall=0 and stall_src=0.
  - Consequence: stop_req[NSTAGE-1] stalls the whole pipe. A lone stop_req[0] gives stall=...0001.
- Counters:
  - stall_cycles increments on each edge where stall!=0.
  - flush_cycles increments on each edge where flush_o=1.
  - Both saturate at all-ones and never wrap.
  - cnt_clr=1 zeroes both counters at the next edge and takes priority over an increment in the same cycle.
- Reset mid-flush aborts the window immediately (async). After reset release, outputs follow the inputs on the first cycle.
- No X propagation: all case/if trees have a default branch.

Optional Feature:
Macro STALL_WATCHDOG_EN.
- Defined:
  - Adds output wd_timeout (1 bit) and an internal counter of consecutive cycles with stall!=0.
  - The counter clears on any cycle with stall==0 or flush_o=1.
  - When the counter reaches WD_LIMIT, wd_timeout sets and stays set (sticky) until reset or cnt_clr.
  - wd_timeout has no effect on stall or flush.
- Undefined: the port and the counter are absent. WD_LIMIT is ignored.

Decomposition:
- Shared package (pipe_ctrl_pkg): the stall-vector type keyed on NSTAGE, and the encodings STOP=1 / NOSTOP=0. Default stage indices are PC=5, MEM=4, EX=3, ID=2, IF=1, WB=0.
- One natural sub-module: hazard_prio_therm. It is purely combinational and maps stop_req to {stall, stall_src}. It is reused by the verification model.
- The flush timer and the counters stay in the top level.

Test Plan:
- Reset: rst=0 with stop_req=6'b111111 -> stall=0, flush_o=0, counters=0. Release rst with stop_req=0 -> all outputs 0.
- Priority: stop_req=6'b000100 -> stall=6'b000111, stall_src=2. Then 6'b010101 -> stall=6'b011111, stall_src=4. Then 6'b100000 -> stall=6'b111111, stall_src=5.
- Flush: FLUSH_HOLD=2, flush_i one-cycle pulse at cycle T with stop_req=6'b111111 -> flush_o=1 and stall=0 in T and T+1; stall=6'b111111 again at T+2. flush_cycles=2.
- Flush extension: FLUSH_HOLD=3, flush_i at T and T+2 -> flush_o=1 for T..T+4 (5 cycles). flush_busy=1 for T+1..T+4.
- Counter saturation and clear: CNT_W=4, hold stop_req=1 for 20 cycles -> stall_cycles=15 (held). Then cnt_clr with stall active -> stall_cycles=0 the next cycle.
- Watchdog (STALL_WATCHDOG_EN, WD_LIMIT=8): stall held 7 cycles then released -> wd_timeout=0. Stall held 8 cycles -> wd_timeout=1 and stays set after the stall is released, until cnt_clr.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller.
//   - NSTAGE_DEF  : default number of pipeline-register stages
//   - stall_vec_t : stall / stop-request vector for the default pipe depth
//   - STOP/NOSTOP : encoding of a single stop-request / stall bit
//   - stage_idx_e : default stage indices (bit 0 is the front of the pipe)
//   - FCNT_W      : width of the flush-window down-counter
//   - flush_load(): value loaded into the flush counter on a flush event
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int NSTAGE_DEF = 6;

  typedef logic [NSTAGE_DEF-1:0] stall_vec_t;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef enum logic [2:0] {
    STG_WB  = 3'd0,
    STG_IF  = 3'd1,
    STG_ID  = 3'd2,
    STG_EX  = 3'd3,
    STG_MEM = 3'd4,
    STG_PC  = 3'd5
  } stage_idx_e;

  localparam int FCNT_W = 4;

  // The cycle carrying flush_i already drives flush_o, so the counter only
  // has to cover the remaining hold-1 cycles.
  function automatic logic [FCNT_W-1:0] flush_load(input int hold);
    return FCNT_W'(hold - 1);
  endfunction

endpackage

// File: rtl/hazard_prio_therm.sv
// -----------------------------------------------------------------------------
// hazard_prio_therm
//   Purely combinational priority / thermometer encoder. The deepest stage
//   requesting a stop wins: every stage at or below it is stalled and its
//   index is reported.
//   Ports:
//     stop_req  in  [NSTAGE-1:0]         per-stage stop requests
//     stall     out [NSTAGE-1:0]         thermometer stall vector
//     stall_src out [$clog2(NSTAGE)-1:0] index of the winning requester
// -----------------------------------------------------------------------------
module hazard_prio_therm
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF
) (
  input  logic [NSTAGE-1:0]         stop_req,
  output logic [NSTAGE-1:0]         stall,
  output logic [$clog2(NSTAGE)-1:0] stall_src
);

  localparam int SRC_W = $clog2(NSTAGE);

  always_comb begin
    logic hit;
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    hit       = NOSTOP;
    stall     = '0;
    stall_src = '0;
    // Scan from the deepest stage towards the front: the first request seen
    // fixes stall_src, and every shallower stage inherits the stall.
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      if (stop_req[j] == STOP && hit == NOSTOP) begin
        stall_src = SRC_W'(j);
      end
      if (stop_req[j] == STOP) begin
        hit = STOP;
      end
      stall[j] = hit;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush arbiter for an in-order pipeline of NSTAGE stages.
//   - Deepest stop requester wins; stall is a thermometer vector.
//   - A flush_i pulse opens a flush window of FLUSH_HOLD cycles; a new pulse
//     inside the window reloads it (no stacking). Flush overrides stalls.
//   - Saturating counters of stall cycles and flush cycles, cleared by cnt_clr.
//   Optional feature (macro STALL_WATCHDOG_EN): sticky wd_timeout once stall
//   has been held for WD_LIMIT consecutive cycles.
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous reset, active-low
//     stop_req     in   [NSTAGE-1:0] per-stage stop requests (bit 0 = front)
//     flush_i      in   flush request pulse
//     cnt_clr      in   synchronous clear of both performance counters
//     stall        out  [NSTAGE-1:0] thermometer stall vector
//     flush_o      out  flush all pipeline registers (zero latency)
//     flush_busy   out  flush window open beyond the current cycle
//     stall_src    out  [$clog2(NSTAGE)-1:0] winning requester, 0 when idle
//     stall_cycles out  [CNT_W-1:0] cycles with stall != 0
//     flush_cycles out  [CNT_W-1:0] cycles with flush_o = 1
//     wd_timeout   out  sticky watchdog flag (STALL_WATCHDOG_EN only)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE     = NSTAGE_DEF,
  parameter int FLUSH_HOLD = 2,
  parameter int CNT_W      = 32
`ifdef STALL_WATCHDOG_EN
  ,
  parameter int WD_LIMIT   = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSTAGE-1:0]         stop_req,
  input  logic                      flush_i,
  input  logic                      cnt_clr,
  output logic [NSTAGE-1:0]         stall,
  output logic                      flush_o,
  output logic                      flush_busy,
  output logic [$clog2(NSTAGE)-1:0] stall_src,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          flush_cycles
`ifdef STALL_WATCHDOG_EN
  ,
  output logic                      wd_timeout
`endif
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = flush_load(FLUSH_HOLD);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  logic [FCNT_W-1:0]         fcnt_q, fcnt_d;
  logic [CNT_W-1:0]          stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]          flush_cycles_q, flush_cycles_d;
  logic [NSTAGE-1:0]         therm_stall;
  logic [$clog2(NSTAGE)-1:0] therm_src;
  logic                      fwin;

  hazard_prio_therm #(
    .NSTAGE (NSTAGE)
  ) u_prio (
    .stop_req  (stop_req),
    .stall     (therm_stall),
    .stall_src (therm_src)
  );

  assign fwin = (fcnt_q != '0);

  // Output decode. The combinational outputs are gated by rst so that they
  // read idle while reset is held, regardless of stop_req / flush_i.
  always_comb begin
    flush_o    = rst & (flush_i | fwin);
    // fcnt_q is held at 0 during reset, so no extra gating is needed here.
    flush_busy = fwin;
    if (!rst || flush_o) begin
      stall     = '0;
      stall_src = '0;
    end else begin
      stall     = therm_stall;
      stall_src = therm_src;
    end
  end

  // Flush window: a new request always reloads, so windows extend rather
  // than accumulate.
  always_comb begin
    fcnt_d = fcnt_q;
    if (flush_i) begin
      fcnt_d = FLUSH_LOAD;
    end else if (fwin) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  // Saturating performance counters; clear beats increment.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (cnt_clr) begin
      stall_cycles_d = '0;
      flush_cycles_d = '0;
    end else begin
      if (stall != '0 && stall_cycles_q != CNT_MAX) begin
        stall_cycles_d = stall_cycles_q + 1'b1;
      end
      if (flush_o && flush_cycles_q != CNT_MAX) begin
        flush_cycles_d = flush_cycles_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q         <= '0;
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      fcnt_q         <= fcnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;

`ifdef STALL_WATCHDOG_EN
  // Watchdog: counts consecutive stalled cycles and saturates at WD_LIMIT.
  localparam int             WD_W   = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_q, wd_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_d     = wd_q;
    if (cnt_clr) begin
      wd_cnt_d = '0;
      wd_d     = 1'b0;
    end else begin
      if (stall == '0 || flush_o) begin
        wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_MAX) begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
      // Sticky: once the limit is reached only reset or cnt_clr clears it.
      if (wd_cnt_d == WD_MAX) begin
        wd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
      wd_q     <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_q     <= wd_d;
    end
  end

  assign wd_timeout = wd_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Instance a uses the default
//   parameters (FLUSH_HOLD=2, CNT_W=32); instance b uses FLUSH_HOLD=3,
//   CNT_W=4 (and WD_LIMIT=8 when STALL_WATCHDOG_EN is defined).
//   Inputs change 1 ns after a rising edge; outputs are sampled 3 ns later.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stall_vec_t  a_stop, a_stall;
  logic        a_fi, a_clr, a_fo, a_busy;
  logic [2:0]  a_src;
  logic [31:0] a_sc, a_fc;

  stall_vec_t  b_stop, b_stall;
  logic        b_fi, b_clr, b_fo, b_busy;
  logic [2:0]  b_src;
  logic [3:0]  b_sc, b_fc;

`ifdef STALL_WATCHDOG_EN
  logic a_wd, b_wd;
`endif

  pipe_hazard_ctrl dut_a (
    .clk          (clk),
    .rst          (rst),
    .stop_req     (a_stop),
    .flush_i      (a_fi),
    .cnt_clr      (a_clr),
    .stall        (a_stall),
    .flush_o      (a_fo),
    .flush_busy   (a_busy),
    .stall_src    (a_src),
    .stall_cycles (a_sc),
    .flush_cycles (a_fc)
`ifdef STALL_WATCHDOG_EN
    ,
    .wd_timeout   (a_wd)
`endif
  );

  pipe_hazard_ctrl #(
    .FLUSH_HOLD (3),
    .CNT_W      (4)
`ifdef STALL_WATCHDOG_EN
    ,
    .WD_LIMIT   (8)
`endif
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .stop_req     (b_stop),
    .flush_i      (b_fi),
    .cnt_clr      (b_clr),
    .stall        (b_stall),
    .flush_o      (b_fo),
    .flush_busy   (b_busy),
    .stall_src    (b_src),
    .stall_cycles (b_sc),
    .flush_cycles (b_fc)
`ifdef STALL_WATCHDOG_EN
    ,
    .wd_timeout   (b_wd)
`endif
  );

  typedef struct {
    stall_vec_t  stop;
    logic        fi;
    logic        clr;
    stall_vec_t  stall;
    logic        fo;
    logic        busy;
    logic [2:0]  src;
    logic [31:0] sc;
    logic [31:0] fc;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flush-extension pattern for instance b: flush_i at k=0 and k=2.
  logic [5:0] ext_fi   = 6'b000101;
  logic [5:0] ext_fo   = 6'b011111;
  logic [5:0] ext_busy = 6'b011110;

  initial begin
    //          stop        fi    clr   stall       fo    busy  src  sc  fc
    tbl[0]  = '{6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'd0, 0, 0};
    tbl[1]  = '{6'b000100, 1'b0, 1'b0, 6'b000111, 1'b0, 1'b0, 3'd2, 0, 0};
    tbl[2]  = '{6'b010101, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 3'd4, 1, 0};
    tbl[3]  = '{6'b100000, 1'b0, 1'b0, 6'b111111, 1'b0, 1'b0, 3'd5, 2, 0};
    tbl[4]  = '{6'b000001, 1'b0, 1'b0, 6'b000001, 1'b0, 1'b0, 3'd0, 3, 0};
    tbl[5]  = '{6'b111111, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd0, 4, 0};
    tbl[6]  = '{6'b111111, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 3'd0, 4, 1};
    tbl[7]  = '{6'b111111, 1'b0, 1'b0, 6'b111111, 1'b0, 1'b0, 3'd5, 4, 2};
    tbl[8]  = '{6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'd0, 5, 2};
    tbl[9]  = '{6'b000000, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 5, 2};
    tbl[10] = '{6'b000010, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 3'd1, 0, 0};
    tbl[11] = '{6'b000010, 1'b0, 1'b1, 6'b000011, 1'b0, 1'b0, 3'd1, 1, 0};
    tbl[12] = '{6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'd0, 0, 0};
    tbl[13] = '{6'b000000, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd0, 0, 0};
    tbl[14] = '{6'b001000, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b1, 3'd0, 0, 1};
    tbl[15] = '{6'b001000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 3'd0, 0, 2};
    tbl[16] = '{6'b001000, 1'b0, 1'b0, 6'b001111, 1'b0, 1'b0, 3'd3, 0, 3};

    // ---------------- reset with all stops and a flush request pending ----
    rst    = 1'b0;
    a_stop = 6'b111111; a_fi = 1'b0; a_clr = 1'b0;
    b_stop = 6'b111111; b_fi = 1'b1; b_clr = 1'b0;
    #3;
    check("rst_a_comb", {a_stall, a_fo, a_busy, a_src}, '0);
    check("rst_b_flush_masked", {b_stall, b_fo, b_busy, b_src}, '0);
    repeat (3) tick();
    check("rst_counters", {a_sc, a_fc, b_sc, b_fc}, '0);

    // Release with idle inputs; the table starts on this cycle.
    a_stop = '0;
    b_stop = '0; b_fi = 1'b0;
    rst    = 1'b1;

    // ---------------- table-driven vectors on instance a -----------------
    for (int i = 0; i < NVEC; i++) begin
      a_stop = tbl[i].stop;
      a_fi   = tbl[i].fi;
      a_clr  = tbl[i].clr;
      #3;
      check($sformatf("vec%0d", i),
            {a_stall, a_fo, a_busy, a_src, a_sc, a_fc},
            {tbl[i].stall, tbl[i].fo, tbl[i].busy, tbl[i].src,
             tbl[i].sc, tbl[i].fc});
      tick();
    end
    a_stop = '0; a_fi = 1'b0; a_clr = 1'b0;

    // ---------------- instance b: flush extension, FLUSH_HOLD=3 ----------
    #3;
    check("b_idle_counters", {b_sc, b_fc}, '0);
    tick();
    b_stop = 6'b000001;
    for (int k = 0; k < 6; k++) begin
      b_fi = ext_fi[k];
      #3;
      check($sformatf("b_ext_k%0d", k),
            {b_fo, b_busy, b_stall, b_src},
            {ext_fo[k], ext_busy[k], (k == 5) ? 6'b000001 : 6'b000000, 3'd0});
      tick();
    end
    b_fi = 1'b0;
    #3;
    check("b_ext_counts", {b_sc, b_fc}, {4'd1, 4'd5});

    // ---------------- instance b: 4-bit saturation and clear -------------
    repeat (20) tick();
    #3;
    check("b_sat", b_sc, 4'd15);
    tick();
    #3;
    check("b_sat_held", b_sc, 4'd15);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    #3;
    check("b_clr_beats_inc", {b_sc, b_fc}, '0);
    tick();
    #3;
    check("b_inc_after_clr", b_sc, 4'd1);

`ifdef STALL_WATCHDOG_EN
    // ---------------- watchdog, WD_LIMIT=8 --------------------------------
    b_stop = '0;
    b_clr  = 1'b1;
    tick();
    b_clr  = 1'b0;
    b_stop = 6'b000001;
    repeat (7) tick();
    b_stop = '0;
    #3;
    check("wd_7_cycles", b_wd, 1'b0);
    tick();
    #3;
    check("wd_7_after", b_wd, 1'b0);
    b_stop = 6'b000001;
    repeat (8) tick();
    b_stop = '0;
    #3;
    check("wd_8_cycles", b_wd, 1'b1);
    repeat (3) tick();
    #3;
    check("wd_sticky", b_wd, 1'b1);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    #3;
    check("wd_cleared", b_wd, 1'b0);
    check("wd_a_quiet", a_wd, 1'b0);
`endif

    // ---------------- reset in the middle of a flush window --------------
    b_stop = '0;
    tick();
    a_fi = 1'b1;
    #3;
    check("mid_flush_start", {a_fo, a_busy}, 2'b10);
    tick();
    a_fi = 1'b0;
    #1;
    check("mid_flush_open", {a_fo, a_busy}, 2'b11);
    rst    = 1'b0;
    a_stop = 6'b000100;
    #1;
    check("mid_flush_abort", {a_fo, a_busy, a_stall, a_src}, '0);
    tick();
    tick();
    rst = 1'b1;
    #3;
    check("post_rst_first_cycle", {a_fo, a_busy, a_stall, a_src},
          {1'b0, 1'b0, 6'b000111, 3'd2});
    check("post_rst_counters", {a_sc, a_fc}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
